// File: rtl/div32_req_sequencer.sv
// Request FIFO and sequencer around the 32-bit signed serial divider.
// Resolves divide-by-zero and INT_MIN/-1 locally; a watchdog bounds the wait for the divider.
module div32_req_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 63
) (
   input  logic             clk,
   input  logic             sync_rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_dividend,
   input  logic [31:0]      req_divisor,
   input  logic [TAG_W-1:0] req_tag,
   output logic             div_valid,
   output logic [31:0]      div_dividend,
   output logic [31:0]      div_divisor,
   input  logic             div_ready,
   input  logic [31:0]      div_q,
   input  logic [31:0]      div_r,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_q,
   output logic [31:0]      rsp_r,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_dz,
   output logic             rsp_err,
   output logic             busy
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_DONE
   } state_t;

   logic [31:0]      r_fifo_a   [DEPTH];
   logic [31:0]      r_fifo_b   [DEPTH];
   logic [TAG_W-1:0] r_fifo_tag [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   state_t           r_state;
   logic [WDW-1:0]   r_wd;
   logic [31:0]      r_div_a;
   logic [31:0]      r_div_b;
   logic [31:0]      r_rsp_q;
   logic [31:0]      r_rsp_r;
   logic [TAG_W-1:0] r_rsp_tag;
   logic             r_rsp_valid;
   logic             r_rsp_dz;
   logic             r_rsp_err;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_head_a;
   logic [31:0]      w_head_b;
   logic [TAG_W-1:0] w_head_tag;
   logic             w_wd_expired;
   logic             w_in_wait;

   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   assign w_push     = req_valid && !w_full;
   assign w_pop      = (r_state == S_IDLE) && !w_empty;
   assign w_head_a   = r_fifo_a[r_rd_ptr];
   assign w_head_b   = r_fifo_b[r_rd_ptr];
   assign w_head_tag = r_fifo_tag[r_rd_ptr];
   assign w_in_wait  = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH);
   // Launch cycle is cycle 0, so the error response lands exactly TIMEOUT cycles after div_valid.
   assign w_wd_expired = w_in_wait && (r_wd == WD_LAST);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr]   <= req_dividend;
         r_fifo_b[r_wr_ptr]   <= req_divisor;
         r_fifo_tag[r_wr_ptr] <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         r_state     <= S_IDLE;
         r_wd        <= '0;
         r_div_a     <= '0;
         r_div_b     <= '0;
         r_rsp_q     <= '0;
         r_rsp_r     <= '0;
         r_rsp_tag   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_dz    <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_div_a   <= w_head_a;
                  r_div_b   <= w_head_b;
                  r_rsp_tag <= w_head_tag;
                  r_rsp_dz  <= 1'b0;
                  r_rsp_err <= 1'b0;
                  if (w_head_b == '0) begin
                     r_rsp_q     <= '1;
                     r_rsp_r     <= w_head_a;
                     r_rsp_dz    <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_head_a == 32'h8000_0000 && w_head_b == 32'hFFFF_FFFF) begin
                     r_rsp_q     <= 32'h8000_0000;
                     r_rsp_r     <= '0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (div_ready) begin
                  r_wd    <= '0;
                  r_state <= S_WAIT_LOW;
               end
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
               r_wd <= r_wd + WDW'(1);
               if (w_wd_expired) begin
                  r_rsp_q     <= '0;
                  r_rsp_r     <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_state == S_WAIT_LOW) begin
                  if (!div_ready) r_state <= S_WAIT_HIGH;
               end else if (div_ready) begin
                  r_rsp_q     <= div_q;
                  r_rsp_r     <= div_r;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = !w_full;
   assign div_valid    = (r_state == S_ISSUE) && div_ready;
   assign div_dividend = r_div_a;
   assign div_divisor  = r_div_b;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_q        = r_rsp_q;
   assign rsp_r        = r_rsp_r;
   assign rsp_tag      = r_rsp_tag;
   assign rsp_dz       = r_rsp_dz;
   assign rsp_err      = r_rsp_err;
   assign busy         = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_div32_req_sequencer.sv
// Scoreboard bench for div32_req_sequencer with a behavioural serial-divider stand-in.
module tb_div32_req_sequencer;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned TIMEOUT = 63;
   localparam int unsigned DIV_LAT = 32;

   typedef struct {
      logic [31:0]      q;
      logic [31:0]      r;
      logic [TAG_W-1:0] tag;
      logic             dz;
      logic             err;
      int               kind;   // 0 local result, 1 divider result, 2 watchdog
   } exp_t;

   logic             clk;
   logic             sync_rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_dividend;
   logic [31:0]      req_divisor;
   logic [TAG_W-1:0] req_tag;
   logic             div_valid;
   logic [31:0]      div_dividend;
   logic [31:0]      div_divisor;
   logic             div_ready;
   logic [31:0]      div_q;
   logic [31:0]      div_r;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_q;
   logic [31:0]      rsp_r;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_dz;
   logic             rsp_err;
   logic             busy;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_launch = 0;
   int   n_rsp = 0;
   int   cyc = 0;
   bit   hang_req = 1'b0;
   bit   rnd_done = 1'b0;

   div32_req_sequencer #(
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .sync_rst_n  (sync_rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_dividend(req_dividend),
      .req_divisor (req_divisor),
      .req_tag     (req_tag),
      .div_valid   (div_valid),
      .div_dividend(div_dividend),
      .div_divisor (div_divisor),
      .div_ready   (div_ready),
      .div_q       (div_q),
      .div_r       (div_r),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_q       (rsp_q),
      .rsp_r       (rsp_r),
      .rsp_tag     (rsp_tag),
      .rsp_dz      (rsp_dz),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Divider stand-in: ready stays high 2 cycles after launch, low while computing, then high with Q/R.
   logic [31:0] m_a, m_b;
   logic        m_busy, m_hang;
   int unsigned m_cnt;
   always @(posedge clk) begin
      if (!sync_rst_n) begin
         m_busy    <= 1'b0;
         m_hang    <= 1'b0;
         m_cnt     <= 0;
         m_a       <= '0;
         m_b       <= '0;
         div_ready <= 1'b1;
         div_q     <= '0;
         div_r     <= '0;
      end else if (!m_busy) begin
         if (div_valid) begin
            m_busy    <= 1'b1;
            m_cnt     <= 0;
            m_a       <= div_dividend;
            m_b       <= div_divisor;
            m_hang    <= hang_req;
            div_ready <= !hang_req;
         end
      end else if (m_hang) begin
         if (!hang_req) begin
            m_busy    <= 1'b0;
            div_ready <= 1'b1;
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == 1) begin
            div_ready <= 1'b0;
         end else if (m_cnt == DIV_LAT + 1) begin
            div_ready <= 1'b1;
            div_q     <= $signed(m_a) / $signed(m_b);
            div_r     <= $signed(m_a) % $signed(m_b);
            m_busy    <= 1'b0;
         end
      end
   end

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [127:0] pack(input logic [31:0] q, r, input logic [TAG_W-1:0] t,
                                         input logic dz, err);
      return {q, r, 32'(t), 30'd0, dz, err};
   endfunction

   function automatic exp_t ref_model(input logic [31:0] a, b, input logic [TAG_W-1:0] t, input bit hang);
      exp_t e;
      int   sa, sbv, sq;
      e.tag = t; e.dz = 1'b0; e.err = 1'b0; e.kind = 0;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 32'd0;
      end else if (hang) begin
         e.q = 32'd0; e.r = 32'd0; e.err = 1'b1; e.kind = 2;
      end else begin
         sa = a; sbv = b;
         sq = sa / sbv;
         e.q = sq; e.r = sa - sq * sbv; e.kind = 1;
      end
      return e;
   endfunction

   // Monitor: latency checks on rsp_valid rise, hold check while stalled, scoreboard pop on handshake.
   initial begin
      exp_t        e;
      logic [127:0] held, act;
      bit          prev_stall = 1'b0;
      logic        prev_rv = 1'b0;
      logic        prev_dr = 1'b1;
      int          launch_cyc = 0;
      int          rise_cyc = 0;
      forever begin
         @(negedge clk);
         if (!sync_rst_n) begin
            prev_stall = 1'b0; prev_rv = 1'b0; prev_dr = 1'b1;
         end else begin
            act = pack(rsp_q, rsp_r, rsp_tag, rsp_dz, rsp_err);
            if (div_valid) begin
               n_launch++;
               launch_cyc = cyc;
            end
            if (div_ready && !prev_dr) rise_cyc = cyc;
            if (rsp_valid && !prev_rv && sb.size() > 0) begin
               if (sb[0].kind == 1) chk("div_latency", 128'(cyc), 128'(rise_cyc + 1));
               else if (sb[0].kind == 2) chk("timeout_latency", 128'(cyc), 128'(launch_cyc + int'(TIMEOUT)));
            end
            if (rsp_valid && prev_stall) chk("rsp_hold", act, held);
            if (rsp_valid && rsp_ready) begin
               n_rsp++;
               if (sb.size() == 0) begin
                  chk("rsp_unexpected", 128'(sb.size()), 128'(1));
               end else begin
                  e = sb.pop_front();
                  chk("rsp", act, pack(e.q, e.r, e.tag, e.dz, e.err));
               end
               prev_stall = 1'b0;
            end else begin
               prev_stall = rsp_valid;
            end
            held    = act;
            prev_rv = rsp_valid;
            prev_dr = div_ready;
         end
      end
   end

   task automatic send(input logic [31:0] a, b, input logic [TAG_W-1:0] t);
      int unsigned n;
      n = 0;
      req_valid = 1'b1; req_dividend = a; req_divisor = b; req_tag = t;
      @(negedge clk);
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", 128'(req_ready), 128'(1));
      if (req_ready) sb.push_back(ref_model(a, b, t, hang_req));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", 128'(sb.size() == 0 && !busy), 128'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int l0, r0;
      logic [31:0] a, b;
      sync_rst_n = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
      req_tag = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", 128'({req_ready, rsp_valid, div_valid, busy, rsp_dz, rsp_err}), 128'(6'b100000));
      chk("reset_data", {rsp_q, rsp_r, div_dividend, div_divisor}, 128'(0));
      chk("reset_tag", 128'(rsp_tag), 128'(0));
      @(posedge clk); #1;
      sync_rst_n = 1'b1;

      // Basic divide
      l0 = n_launch; r0 = n_rsp;
      send(32'd100, 32'd7, 4'd3);
      drain();
      chk("t1_launches", 128'(n_launch - l0), 128'(1));
      chk("t1_responses", 128'(n_rsp - r0), 128'(1));
      chk("t1_operands", 128'({div_dividend, div_divisor}), 128'({32'd100, 32'd7}));

      // Signed ordering
      send(-32'sd100, 32'd7, 4'd1);
      send(32'd100, -32'sd7, 4'd2);
      drain();

      // Local results never reach the divider
      l0 = n_launch;
      send(32'd5, 32'd0, 4'd5);
      send(32'h8000_0000, 32'hFFFF_FFFF, 4'd6);
      drain();
      chk("t3_no_launch", 128'(n_launch - l0), 128'(0));

      // Back-pressure: DEPTH in the FIFO plus one held by the FSM
      rsp_ready = 1'b0;
      for (int unsigned i = 0; i < DEPTH + 1; i++)
         send(i * 1000 + 17, i + 3, 4'(8 + i));
      @(negedge clk);
      chk("t4_full", 128'(req_ready), 128'(0));
      repeat (60) @(negedge clk);
      chk("t4_stall", 128'({req_ready, rsp_valid}), 128'(2'b01));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();

      // Hung divider
      hang_req = 1'b1;
      send(32'd1000, 32'd3, 4'd7);
      drain();
      hang_req = 1'b0;
      send(32'd1000, 32'd3, 4'd8);
      drain();

      // Reset with one in flight and two queued
      send(32'd77, 32'd5, 4'd9);
      send(32'd78, 32'd5, 4'd10);
      send(32'd79, 32'd5, 4'd11);
      repeat (10) @(posedge clk);
      #1;
      sync_rst_n = 1'b0;
      @(posedge clk); #1;
      sync_rst_n = 1'b1;
      sb.delete();
      r0 = n_rsp;
      @(negedge clk);
      chk("t6_after_reset", 128'({req_ready, rsp_valid, busy}), 128'(3'b100));
      repeat (100) @(negedge clk);
      chk("t6_dropped", 128'(n_rsp - r0), 128'(0));
      @(posedge clk); #1;
      send(32'd81, 32'd9, 4'd12);
      drain();

      // Randomized traffic with random downstream stalls
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               case ($urandom_range(0, 9))
                  0: begin a = $urandom(); b = 32'd0; end
                  1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                  2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                  default: begin
                     a = $urandom() >> $urandom_range(0, 31);
                     b = $urandom() >> $urandom_range(0, 31);
                     if ($urandom_range(0, 1) == 1) a = -a;
                     if ($urandom_range(0, 1) == 1) b = -b;
                  end
               endcase
               send(a, b, 4'($urandom()));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();
      chk("sb_empty", 128'(sb.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
